// File: rtl/add_rr_sched_pkg.sv
// Shared types and constants for the round-robin accumulate-adder scheduler.
package add_rr_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sched_state_e;

  localparam int N_REQ_MAX = 8;

  localparam int RES_RST_VAL = 0;
  localparam int CNT_RST_VAL = 0;

endpackage

// File: rtl/add_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Zero latency; gnt is forced to zero when en is low, gnt_id still reports the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IDW = $clog2(N);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_id   = idx;
        gnt[idx] = en;
      end
    end
  end

endmodule

// File: rtl/add_rr_sched.sv
// Round-robin scheduler sharing one W-bit adder; result lands in a one-entry output register.
// Latency 1 cycle, full throughput with res_ready high; ADD_RR_SCHED_CNT_EN adds op_cnt into the sum.
module add_rr_sched
  import add_rr_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_data,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [W-1:0]             op_cnt
);

  localparam int IDW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
    $error("add_rr_sched: N_REQ out of range");
  end

  sched_state_e   state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic [N_REQ-1:0] gnt;
  logic           acc_en;
  logic           accept;
  logic [W-1:0]   op_a, op_b, sum;

  assign acc_en = (state == EMPTY) | res_ready;

  // Gating en with rst_n keeps req_ready low throughout reset.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (acc_en & rst_n),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign res_valid = (state == FULL);

  assign op_a = req_a[gnt_id*W +: W];
  assign op_b = req_b[gnt_id*W +: W];

`ifdef ADD_RR_SCHED_CNT_EN
  assign sum = op_a + op_b + op_cnt;
`else
  assign sum = op_a + op_b;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (res_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      res_data <= W'(RES_RST_VAL);
      res_id   <= '0;
      op_cnt   <= W'(CNT_RST_VAL);
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_data <= sum;
        res_id   <= gnt_id;
        op_cnt   <= op_cnt + 1'b1;
        rr_ptr   <= (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

endmodule

// File: doc/add_rr_sched.md
# add_rr_sched

Round-robin scheduler that shares the single 8-bit accumulate-adder datapath of the top-level design between several requesters. Each requester offers an operand pair over a valid/ready handshake. The scheduler grants one requester per accepted operation and computes `a + b + op_cnt` in the shared adder. It returns the result, tagged with the requester index, through a one-entry output register with its own valid/ready handshake. It sits between the user-I/O decode logic and the output pins inside the top-level wrapper.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `W`, default 8: operand, result and counter width.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `req_valid` input, `N_REQ` bits: requester i has an operand pair pending.
- `req_ready` output, `N_REQ` bits: one-hot or zero; the pair is accepted on `req_valid[i] & req_ready[i]`.
- `req_a` input, `N_REQ*W` bits: operand A; slice i is `[i*W +: W]`.
- `req_b` input, `N_REQ*W` bits: operand B; same packing as `req_a`.
- `res_valid` output, 1 bit: output register holds a result.
- `res_ready` input, 1 bit: consumer takes the result.
- `res_data` output, `W` bits: result.
- `res_id` output, `$clog2(N_REQ)` bits: index of the requester that produced the result.
- `op_cnt` output, `W` bits: count of accepted operations, modulo 2^W.

## Operation
- FSM states: EMPTY (output register empty) and FULL (output register holds a result).
  - EMPTY → FULL on an accept.
  - FULL → EMPTY when `res_ready` is high and there is no accept.
  - FULL → FULL when `res_ready` is high and there is an accept (back-to-back), or when `res_ready` is low (hold).
- Accept enable: `acc_en = (state == EMPTY) | res_ready`.
- Grant:
  - Winner = first i with `req_valid[i]` high, searching circularly from `rr_ptr`.
  - `req_ready[winner] = acc_en`; every other bit of `req_ready` is 0.
  - `req_ready` is all zero when no `req_valid` is high.
- On accept:
  - `res_data <= (req_a[w] + req_b[w] + op_cnt)` mod 2^W, carry discarded. `op_cnt` here is the pre-increment value.
  - `res_id <= w`.
  - `op_cnt <= op_cnt + 1`; wraps from 2^W-1 to 0.
  - `rr_ptr <= (w + 1) mod N_REQ`.
- With no accept, `rr_ptr` and `op_cnt` are unchanged.
- While FULL and `res_ready` is low, `res_data` and `res_id` are held stable.
- `res_valid = (state == FULL)`.

## Timing
- Reset values: state EMPTY, `res_valid` 0, `res_data` 0, `res_id` 0, `op_cnt` 0, `rr_ptr` 0.
  - `req_ready` is 0 during reset (combinational, gated by `rst_n`).
- Latency: a pair accepted at edge k appears with `res_valid` high after edge k. It is visible in cycle k+1.
- Throughput: one operation per cycle while `res_ready` is held high.
- `req_ready` depends combinationally on `req_valid`, `res_ready`, the state and `rr_ptr`. It never depends on `req_a` or `req_b`.
- A requester may not withdraw `req_valid` or change its operands until it is accepted. The scheduler does not check this.
- Simultaneous `res_ready` and new accept in FULL: the old result is consumed and the new result is loaded on the same edge, with no bubble.
- If `rst_n` is asserted mid-operation, the pending result is discarded. `op_cnt` and `rr_ptr` return to 0 on the next edge.
- A requester whose `req_valid` is continuously high is granted within `N_REQ` accepts (no starvation).

## Configuration
- Macro: `ADD_RR_SCHED_CNT_EN`.
- Defined: `op_cnt` is added into the result as described above.
- Not defined:
  - `res_data = a + b` mod 2^W.
  - The `op_cnt` register still exists and still counts accepts; only the adder term is removed.

## Structure
- Package `add_rr_sched_pkg` holds:
  - the state enum `sched_state_e` (EMPTY, FULL);
  - `N_REQ_MAX = 8`;
  - the reset constants for the result and counter.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and binary `gnt_id`.
  - Purely combinational; the pointer register lives in the parent.
- `add_rr_sched` owns the FSM, the output register, `op_cnt`, `rr_ptr` and the adder.

## Test plan
- Reset with all `req_valid` high and `rst_n` low → `req_ready` = 0, `res_valid` = 0, `op_cnt` = 0 throughout reset.
- Single request, requester 2, a = 0x10, b = 0x05, `res_ready` = 1 → one cycle later `res_valid` = 1, `res_data` = 0x15, `res_id` = 2; afterwards `op_cnt` = 1.
- All 4 requesters valid, `res_ready` = 1 → grant order 0, 1, 2, 3, 0 on consecutive cycles; `res_id` follows one cycle behind; `res_valid` stays 1.
- Backpressure: `res_ready` = 0 for 3 cycles while FULL → `req_ready` = 0, and `res_data`/`res_id` are stable; when `res_ready` rises, the next pair is accepted in that same cycle.
- Wrap-around: preload 255 accepts, then a = 0xFF, b = 0x02 → `res_data` = (0xFF + 0x02 + 0xFF) mod 256 = 0x00, and `op_cnt` wraps to 0. Without the macro, expect 0x01.
- Reset asserted while FULL with requester 1 granted last → next cycle `res_valid` = 0; after release, requester 0 wins even if requester 1 is also valid.
